// File: rtl/ram_store_unit.sv
// Byte-serial big-endian store engine for the byte-wide data RAM write port.
// Define MISALIGN_TRAP_EN to reject misaligned SH/SW with an err pulse.
module ram_store_unit #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [2:0]        req_sel,
  input  logic [31:0]       req_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_cnt;
  logic [1:0]        r_last;
  logic [31:0]       r_data;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_last;
  logic              w_ready;
  logic              w_accept;
  logic              w_legal;
  logic              w_go;
  logic              w_step;
  logic [1:0]        w_nlast;
  logic [31:0]       w_aligned;
  logic [1:0]        w_cnt;
  logic [1:0]        w_last_n;
  logic [31:0]       w_data;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_wdata;
  logic              w_busy;
  logic              w_done;
  logic              w_err;
  logic              w_unused;

  assign w_unused = ^req_addr[31:ADDR_W];

  assign w_last   = (r_cnt == r_last);
  assign w_ready  = (r_state == S_IDLE) || w_last;
  assign w_accept = req_valid && w_ready;
  assign w_go     = w_accept && w_legal;
  assign w_step   = (r_state == S_WRITE) && !w_last;

  assign req_ready = w_ready;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

  // Left-align the store data so byte k is always the top byte after k shifts
  always_comb begin
    w_legal   = 1'b1;
    w_nlast   = 2'd0;
    w_aligned = {req_data[7:0], 24'h0};
    case (req_sel)
      3'b000: ;
      3'b001: begin
        w_nlast   = 2'd1;
        w_aligned = {req_data[15:0], 16'h0};
      end
      3'b010: begin
        w_nlast   = 2'd3;
        w_aligned = req_data;
      end
      default: w_legal = 1'b0;
    endcase
`ifdef MISALIGN_TRAP_EN
    if (req_sel == 3'b001 && req_addr[0])
      w_legal = 1'b0;
    if (req_sel == 3'b010 && req_addr[1:0] != 2'b00)
      w_legal = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_last  <= '0;
      r_data  <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt;
      r_last  <= w_last_n;
      r_data  <= w_data;
      r_we    <= w_we;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_err   <= w_err;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_go) w_state_nxt = S_WRITE;
      S_WRITE: if (w_last) w_state_nxt = w_go ? S_WRITE : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Address and data hold their last value whenever no byte is written
  always_comb begin
    w_we     = 1'b0;
    w_addr   = r_addr;
    w_wdata  = r_wdata;
    w_busy   = 1'b0;
    w_done   = 1'b0;
    w_err    = w_accept && !w_legal;
    w_cnt    = r_cnt;
    w_last_n = r_last;
    w_data   = r_data;
    unique case (1'b1)
      w_go: begin
        w_we     = 1'b1;
        w_addr   = req_addr[ADDR_W-1:0];
        w_wdata  = w_aligned[31:24];
        w_data   = w_aligned << 8;
        w_cnt    = 2'd0;
        w_last_n = w_nlast;
        w_done   = (w_nlast == 2'd0);
        w_busy   = 1'b1;
      end
      w_step: begin
        w_we    = 1'b1;
        w_addr  = r_addr + 1'b1;
        w_wdata = r_data[31:24];
        w_data  = r_data << 8;
        w_cnt   = r_cnt + 2'd1;
        w_done  = (w_cnt == r_last);
        w_busy  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_store_unit.sv
// Scoreboard bench for ram_store_unit: expected byte writes / err pulses
// are queued at issue time and popped by a negedge monitor.
module tb_ram_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_sel = '0;
  logic [31:0] req_data = '0;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct {
    bit         is_err;
    logic [11:0] a;
    logic [7:0]  d;
    bit         dn;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int run = 0;
  int max_run = 0;

  ram_store_unit #(.ADDR_W(12)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_sel(req_sel), .req_data(req_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic exp_w(input logic [11:0] a, input logic [7:0] d, input bit dn);
    exp_t e;
    e.is_err = 0; e.a = a; e.d = d; e.dn = dn;
    q.push_back(e);
  endtask

  task automatic exp_e();
    exp_t e;
    e.is_err = 1; e.a = '0; e.d = '0; e.dn = 0;
    q.push_back(e);
  endtask

  task automatic issue(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    int n = 0;
    req_valid = 1'b1;
    req_addr = a;
    req_sel = s;
    req_data = d;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL ready_timeout addr=%h got ready=0 want 1", a);
    end else begin
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we) run++;
    else run = 0;
    if (run > max_run) max_run = run;
    if (mem_we || err) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected we=%b err=%b addr=%h data=%h want nothing",
                 mem_we, err, mem_addr, mem_wdata);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.is_err) begin
          if (!(err && !mem_we && !done)) begin
            bad++;
            $display("FAIL err_pulse got err=%b we=%b done=%b want err=1 we=0 done=0",
                     err, mem_we, done);
          end
        end else if ({mem_addr, mem_wdata, done, busy, err} !== {e.a, e.d, e.dn, 1'b1, 1'b0}) begin
          bad++;
          $display("FAIL write got a=%h d=%h done=%b busy=%b err=%b want a=%h d=%h done=%b busy=1 err=0",
                   mem_addr, mem_wdata, done, busy, err, e.a, e.d, e.dn);
        end
      end
    end else begin
      total++;
      if (done || busy) begin
        bad++;
        $display("FAIL idle got done=%b busy=%b want 0 0", done, busy);
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("reset_outs", {19'(mem_addr), mem_wdata, mem_we, busy, done, err}, 32'h0);
    check("reset_ready", {31'h0, req_ready}, 32'h1);
    rst = 1'b0;
    @(posedge clk); #1;

    exp_w(12'h010, 8'h11, 0);
    exp_w(12'h011, 8'h22, 0);
    exp_w(12'h012, 8'h33, 0);
    exp_w(12'h013, 8'h44, 1);
    issue(32'h010, 3'b010, 32'h11223344);
    repeat (5) @(posedge clk); #1;

    exp_w(12'h020, 8'hBE, 0);
    exp_w(12'h021, 8'hEF, 1);
    issue(32'h020, 3'b001, 32'hDEADBEEF);
    repeat (3) @(posedge clk); #1;

    exp_w(12'h030, 8'hEF, 1);
    issue(32'h030, 3'b000, 32'hDEADBEEF);
    repeat (3) @(posedge clk); #1;

    max_run = 0;
    exp_w(12'h100, 8'hCA, 0);
    exp_w(12'h101, 8'hFE, 0);
    exp_w(12'h102, 8'hF0, 0);
    exp_w(12'h103, 8'h0D, 1);
    exp_w(12'h200, 8'h5A, 1);
    issue(32'h100, 3'b010, 32'hCAFEF00D);
    issue(32'h200, 3'b000, 32'h0000005A);
    repeat (4) @(posedge clk); #1;
    check("b2b_run", max_run, 5);

    exp_e();
    issue(32'h040, 3'b011, 32'h12345678);
    check("illegal_ready", {31'h0, req_ready}, 32'h1);
    repeat (3) @(posedge clk); #1;

    exp_e();
    issue(32'h050, 3'b111, 32'h12345678);
    repeat (3) @(posedge clk); #1;

`ifdef MISALIGN_TRAP_EN
    exp_e();
`else
    exp_w(12'hFFE, 8'hA1, 0);
    exp_w(12'hFFF, 8'hB2, 0);
    exp_w(12'h000, 8'hC3, 0);
    exp_w(12'h001, 8'hD4, 1);
`endif
    issue(32'hFFE, 3'b010, 32'hA1B2C3D4);
    repeat (5) @(posedge clk); #1;

`ifdef MISALIGN_TRAP_EN
    exp_e();
`else
    exp_w(12'h041, 8'h12, 0);
    exp_w(12'h042, 8'h34, 1);
`endif
    issue(32'h041, 3'b001, 32'h00001234);
    repeat (3) @(posedge clk); #1;

    exp_w(12'h300, 8'h01, 0);
    exp_w(12'h301, 8'h02, 0);
    issue(32'h300, 3'b010, 32'h01020304);
    @(posedge clk); #1;
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_abort", {29'h0, mem_we, busy, done}, 32'h0);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    repeat (6) @(posedge clk); #1;

    check("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_store_unit.md
Name: ram_store_unit

Overview:
- Write-side companion to the byte-array data RAM read port: converts one store request (SB/SH/SW) into a sequence of byte writes, one byte per clock.
- Uses the same big-endian byte order as the load path: mem[addr] holds the most significant stored byte.
- Sits between the execute/memory stage and the byte-wide RAM write port, with a valid/ready request handshake and done/err completion pulses.

Parameters:
- ADDR_W, 12, byte-address width of the RAM write port (4096 bytes); addresses wrap modulo 2^ADDR_W.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  store request present
- req_ready  output  1  unit can accept a request this cycle
- req_addr  input  32  byte address of store; only [ADDR_W-1:0] used
- req_sel  input  3  funct3 encoding: 000 SB, 001 SH, 010 SW; all other values illegal
- req_data  input  32  store data, right-aligned (SB uses [7:0], SH uses [15:0])
- mem_we  output  1  byte write strobe to RAM
- mem_addr  output  ADDR_W  byte address for the current write
- mem_wdata  output  8  byte to write
- busy  output  1  store in progress (state WRITE)
- done  output  1  one-cycle pulse, concurrent with the last byte write
- err  output  1  one-cycle pulse: request rejected, no bytes written

Behaviour:
- Reset (async) values: state IDLE, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0, busy=0, byte counter 0.
- Reset mid-store: writing aborts immediately, remaining bytes are discarded, and no done pulse is produced.
- States:
  - IDLE: req_ready=1.
  - WRITE: req_ready=1 only in the last-byte cycle, otherwise 0.
- Accept: an accept happens on a rising edge where req_valid && req_ready. addr, sel and data are latched. Byte count N is 1 for SB, 2 for SH, 4 for SW.
- Byte order, big-endian:
  - SW: byte k (k=0..3) goes to addr+k with data[31-8k -: 8].
  - SH: addr gets data[15:8], addr+1 gets data[7:0].
  - SB: addr gets data[7:0].
- Timing:
  - All outputs are registered.
  - Byte 0 write (mem_we=1) occurs in the cycle after the accept edge. Byte k occurs k cycles later.
  - done=1 in the cycle of byte N-1.
  - busy=1 for exactly N cycles.
- Back-to-back: a new accept in the last-byte cycle loads the new request. Its byte 0 appears in the next cycle, with no bubble and mem_we continuously high.
- If no new request arrives at the last byte, the unit returns to IDLE and mem_we=0 the next cycle.
- Address arithmetic: mem_addr = (addr[ADDR_W-1:0] + k) mod 2^ADDR_W. A store at 0xFFE with SW writes 0xFFE, 0xFFF, 0x000, 0x001.
- Illegal sel: the handshake completes and nothing is written. err=1 in the cycle after accept. The unit stays in, or returns to, IDLE with req_ready=1. done stays 0.
- mem_wdata and mem_addr hold their last values when mem_we=0.
- No read-after-write interlock inside the unit: the pipeline must stall loads while busy=1.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- When defined:
  - SH with addr[0]=1 is treated exactly as illegal sel: accepted, no writes, err pulse.
  - SW with addr[1:0]!=00 is treated the same way.
- When undefined: any alignment is written byte-by-byte as above, including across the wrap boundary.

Test Plan:
- Reset then SW, addr=0x010, data=0x11223344 -> mem_we high 4 cycles, writing 0x010=0x11, 0x011=0x22, 0x012=0x33, 0x013=0x44. done only with the 0x013 write. busy=1 for 4 cycles.
- SH addr=0x020, data=0xDEADBEEF -> 0x020=0xBE, 0x021=0xEF. SB addr=0x030, same data -> single write 0x030=0xEF, done in the same cycle.
- SW 0x100 held valid, followed by SB 0x200 data 0x5A presented during the last byte -> accepted with no bubble. Writes 0x100..0x103 then 0x200=0x5A over 5 consecutive mem_we cycles.
- req_sel=011 -> no mem_we, err pulse 1 cycle after accept, req_ready stays 1.
- SW addr=0xFFE data=0xA1B2C3D4, macro undefined -> 0xFFE=A1, 0xFFF=B2, 0x000=C3, 0x001=D4. Same request with MISALIGN_TRAP_EN -> no writes, err pulse.
- Assert rst after the second byte of an SW -> mem_we=0 immediately. Remaining two bytes never written, no done, req_ready=1 after release.
